// File: rtl/bcd_digit_encoder.sv
// bcd_digit_encoder: sequential double-dabble binary-to-BCD converter, one bit per clock, saturating to all nines.
// Define BCD_LEADING_ZERO_BLANK_EN to drive the leading-zero blank mask; otherwise o_blank is tied to 0.
module bcd_digit_encoder #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_value,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_digits,
    output logic                  o_ovf,
    output logic [DIGITS-1:0]     o_blank
);
    function automatic logic [31:0] max_val(input int d);
        logic [31:0] m;
        m = 32'd1;
        for (int i = 0; i < d; i++) m = m * 32'd10;
        return m - 32'd1;
    endfunction

    localparam int          SW   = 4 * DIGITS;
    localparam int          CW   = $clog2(WIDTH + 1);
    localparam logic [31:0] MAXV = max_val(DIGITS);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_shift, w_shift_sh;
    logic [SW-1:0]       r_scratch, w_adj, w_scratch_sh, w_result, r_digits;
    logic [CW-1:0]       r_count;
    logic                r_ovf_pend, r_ovf, w_ovf;
    logic [DIGITS-1:0]   r_blank, w_blank;

    assign w_ovf = 32'(i_value) > MAXV;

    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++)
            w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ? r_scratch[4*d +: 4] + 4'd3 : r_scratch[4*d +: 4];
    end

    assign w_scratch_sh = {w_adj[SW-2:0], r_shift[WIDTH-1]};
    assign w_shift_sh   = {r_shift[WIDTH-2:0], 1'b0};
    assign w_result     = r_ovf_pend ? {DIGITS{4'h9}} : w_scratch_sh;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic w_run;
    // Walk down from the most significant digit; digit 0 is never blanked.
    always_comb begin
        w_run   = 1'b1;
        w_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run      = w_run & (w_result[4*i +: 4] == 4'd0);
            w_blank[i] = w_run & ~r_ovf_pend;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE && i_start)            ? CONV :
                      (r_state == CONV && r_count == CW'(1))  ? DONE :
                      (r_state == DONE)                       ? IDLE : r_state;
    end

    // Results are captured on the final shift so they are already stable during DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_count    <= '0;
            r_ovf_pend <= 1'b0;
            r_digits   <= '0;
            r_ovf      <= 1'b0;
            r_blank    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && i_start) begin
                r_shift    <= i_value;
                r_scratch  <= '0;
                r_count    <= CW'(WIDTH);
                r_ovf_pend <= w_ovf;
            end else if (r_state == CONV) begin
                r_shift   <= w_shift_sh;
                r_scratch <= w_scratch_sh;
                r_count   <= r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    r_digits <= w_result;
                    r_ovf    <= r_ovf_pend;
                    r_blank  <= w_blank;
                end
            end
        end
    end

    assign o_busy   = r_state == CONV;
    assign o_valid  = r_state == DONE;
    assign o_digits = r_digits;
    assign o_ovf    = r_ovf;
    assign o_blank  = r_blank;
endmodule
